// File: rtl/enemy_fire_scheduler_if.sv
// Shot request bus between the enemy fire scheduler and the projectile datapath.
// Handshake: master raises fire_valid with stable slot/col/row; the request is
// consumed on the first rising clk edge where fire_ack is high, and fire_valid
// stays high (payload unchanged) until that edge.
interface enemy_fire_scheduler_if;
  logic       fire_valid;
  logic       fire_ack;
  logic [2:0] fire_slot;
  logic [5:0] fire_col;
  logic [5:0] fire_row;

  modport master (
    output fire_valid, fire_slot, fire_col, fire_row,
    input  fire_ack
  );

  modport slave (
    input  fire_valid, fire_slot, fire_col, fire_row,
    output fire_ack
  );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// Enemy shot scheduler: cooldown, LFSR start column, nearest live column,
// lowest live enemy in it, first free bullet slot, then valid/ack to the datapath.
module enemy_fire_scheduler #(
  parameter int          LINHAS    = 4,
  parameter int          COLUNAS   = 8,
  parameter int          N_TIROS   = 3,
  parameter logic [25:0] COOLDOWN  = 26'd25_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_i,
  input  logic [LINHAS*COLUNAS-1:0] enemy_vivos_i,
  input  logic [N_TIROS-1:0]        tiro_livre_i,
  enemy_fire_scheduler_if.master    fire_if,
  output logic                      no_shooter_o,
  output logic [7:0]                shots_fired_o,
  output logic [2:0]                state_o
);
  localparam int COL_W = $clog2(COLUNAS);
  localparam int ROW_W = $clog2(LINHAS);
  localparam logic [25:0] CD_RELOAD = COOLDOWN - 26'd1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PICK     = 3'd1,
    S_SCAN_COL = 3'd2,
    S_SCAN_ROW = 3'd3,
    S_SLOT     = 3'd4,
    S_FIRE     = 3'd5
  } state_e;

  state_e            state_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic [25:0]       cd_q;
  logic [COL_W-1:0]  col_q;
  logic [COL_W-1:0]  tries_q;
  logic [COL_W-1:0]  col_d;
  logic [COL_W-1:0]  pick_col;
  logic [ROW_W-1:0]  row_q;
  logic              fire_valid_q;
  logic [2:0]        fire_slot_q;
  logic [5:0]        fire_col_q;
  logic [5:0]        fire_row_q;
  logic              no_shooter_q;
  logic [7:0]        shots_q;
  logic [LINHAS-1:0] col_bits;
  logic              col_any;
  logic              row_hit;
  logic              slot_any;
  logic [2:0]        slot_idx;

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  end

  assign pick_col = COL_W'(lfsr_q % 16'(COLUNAS));
  assign col_d    = (col_q == COL_W'(COLUNAS - 1)) ? '0 : col_q + 1'b1;

  // Live flags of the column under scan, indexed by row.
  always_comb begin
    col_bits = '0;
    for (int c = 0; c < COLUNAS; c++) begin
      if (col_q == COL_W'(c)) begin
        for (int r = 0; r < LINHAS; r++) begin
          col_bits[r] = enemy_vivos_i[r*COLUNAS + c];
        end
      end
    end
  end

  assign col_any = |col_bits;
  assign row_hit = col_bits[row_q];

  always_comb begin
    slot_idx = '0;
    for (int i = N_TIROS - 1; i >= 0; i--) begin
      if (tiro_livre_i[i]) slot_idx = 3'(i);
    end
  end

  assign slot_any = |tiro_livre_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      cd_q         <= CD_RELOAD;
      col_q        <= '0;
      tries_q      <= '0;
      row_q        <= '0;
      fire_valid_q <= 1'b0;
      fire_slot_q  <= '0;
      fire_col_q   <= '0;
      fire_row_q   <= '0;
      no_shooter_q <= 1'b0;
      shots_q      <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      no_shooter_q <= 1'b0;
      // Losing enable aborts any search; a request already on the bus is kept.
      if (!enable_i && (state_q inside {S_PICK, S_SCAN_COL, S_SCAN_ROW, S_SLOT})) begin
        state_q <= S_IDLE;
        cd_q    <= CD_RELOAD;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (enable_i) begin
              if (cd_q == '0) state_q <= S_PICK;
              else            cd_q    <= cd_q - 26'd1;
            end
          end
          S_PICK: begin
            col_q   <= pick_col;
            tries_q <= '0;
            state_q <= S_SCAN_COL;
          end
          S_SCAN_COL: begin
            if (col_any) begin
              row_q   <= ROW_W'(LINHAS - 1);
              state_q <= S_SCAN_ROW;
            end else if (tries_q == COL_W'(COLUNAS - 1)) begin
              no_shooter_q <= 1'b1;
              state_q      <= S_IDLE;
              cd_q         <= CD_RELOAD;
            end else begin
              col_q   <= col_d;
              tries_q <= tries_q + 1'b1;
            end
          end
          S_SCAN_ROW: begin
            if (row_hit) begin
              fire_col_q <= 6'(col_q);
              fire_row_q <= 6'(row_q);
              state_q    <= S_SLOT;
            end else if (row_q == '0) begin
              // Column emptied while being scanned: start over from a new column.
              state_q <= S_PICK;
            end else begin
              row_q <= row_q - 1'b1;
            end
          end
          S_SLOT: begin
            if (slot_any) begin
              fire_slot_q  <= slot_idx;
              fire_valid_q <= 1'b1;
              state_q      <= S_FIRE;
            end
          end
          S_FIRE: begin
            if (fire_if.fire_ack) begin
              fire_valid_q <= 1'b0;
              shots_q      <= shots_q + 8'd1;
              state_q      <= S_IDLE;
              cd_q         <= CD_RELOAD;
            end
          end
          default: begin
            fire_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            cd_q         <= CD_RELOAD;
          end
        endcase
      end
    end
  end

  assign fire_if.fire_valid = fire_valid_q;
  assign fire_if.fire_slot  = fire_slot_q;
  assign fire_if.fire_col   = fire_col_q;
  assign fire_if.fire_row   = fire_row_q;
  assign no_shooter_o       = no_shooter_q;
  assign shots_fired_o      = shots_q;
  assign state_o            = state_q;
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Bench for enemy_fire_scheduler: expected shots {slot,col,row} are queued when a
// grid is driven and compared when fire_valid rises.
module tb_enemy_fire_scheduler;
  localparam int          LINHAS   = 4;
  localparam int          COLUNAS  = 8;
  localparam int          N_TIROS  = 3;
  localparam logic [25:0] COOLDOWN = 26'd4;
  localparam int          CD       = 4;
  localparam int          BUDGET   = 80;

  logic                      clk;
  logic                      reset;
  logic                      enable;
  logic [LINHAS*COLUNAS-1:0] enemy_vivos;
  logic [N_TIROS-1:0]        tiro_livre;
  logic                      no_shooter;
  logic [7:0]                shots_fired;
  logic [2:0]                state;

  enemy_fire_scheduler_if bus ();

  enemy_fire_scheduler #(
    .LINHAS   (LINHAS),
    .COLUNAS  (COLUNAS),
    .N_TIROS  (N_TIROS),
    .COOLDOWN (COOLDOWN),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .enemy_vivos_i(enemy_vivos),
    .tiro_livre_i (tiro_livre),
    .fire_if      (bus),
    .no_shooter_o (no_shooter),
    .shots_fired_o(shots_fired),
    .state_o      (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q[$];
  logic [7:0]  exp_shots;
  int          n_vec;
  int          n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] low_slot(input logic [2:0] t);
    logic [2:0] r;
    r = '0;
    for (int i = 2; i >= 0; i--) if (t[i]) r = 3'(i);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_shots = 8'd0;
  endtask

  // Waits for the next request, checks it against the queue, holds it for
  // ack_dly cycles, acks, and returns on the negedge after the ack edge.
  task automatic take_shot(input int ack_dly);
    int          n;
    logic [14:0] e;
    n = 0;
    while (!bus.fire_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq("valid_rise", 32'(bus.fire_valid), 32'd1);
    if (!bus.fire_valid) return;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h7fff;
    check_eq("shot", {bus.fire_slot, bus.fire_col, bus.fire_row}, e);
    repeat (ack_dly) begin
      @(negedge clk);
      check_eq("valid_hold", {bus.fire_valid, bus.fire_slot, bus.fire_col, bus.fire_row}, {1'b1, e});
    end
    bus.fire_ack = 1'b1;
    @(negedge clk);
    bus.fire_ack = 1'b0;
    exp_shots++;
    check_eq("valid_drop", 32'(bus.fire_valid), 32'd0);
    check_eq("shots_fired", 32'(shots_fired), 32'(exp_shots));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.fire_valid), 32'd0);
    check_eq({tag, "_slot"},  32'(bus.fire_slot),  32'd0);
    check_eq({tag, "_col"},   32'(bus.fire_col),   32'd0);
    check_eq({tag, "_row"},   32'(bus.fire_row),   32'd0);
    check_eq({tag, "_nosh"},  32'(no_shooter),     32'd0);
    check_eq({tag, "_shots"}, 32'(shots_fired),    32'd0);
    check_eq({tag, "_state"}, 32'(state),          32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [14:0] e;
    logic [2:0]  t;
    logic [3:0]  rows;
    int          c;
    int          hr;
    int          n;
    int          last;
    int          npulse;
    logic        prev;
    logic        saw_valid;
    logic        bad;

    n_vec       = 0;
    n_err       = 0;
    exp_shots   = 8'd0;
    reset       = 1'b1;
    enable      = 1'b0;
    enemy_vivos = '0;
    tiro_livre  = '0;
    bus.fire_ack = 1'b0;

    // Reset values
    do_reset();
    check_reset_outputs("reset");

    // Single enemy at row 1, col 5
    enable      = 1'b1;
    enemy_vivos = 32'h1 << 13;
    tiro_livre  = 3'b111;
    exp_q.push_back({3'd0, 6'd5, 6'd1});
    take_shot(1);

    // Column 2 rows 0 and 3: bottom one always fires
    enemy_vivos = (32'h1 << 2) | (32'h1 << 26);
    for (int k = 0; k < 4; k++) begin
      t = 3'($urandom_range(1, 7));
      tiro_livre = t;
      exp_q.push_back({low_slot(t), 6'd2, 6'd3});
      take_shot($urandom_range(0, 3));
    end

    // Empty grid: periodic single-cycle no_shooter, never a request
    enemy_vivos = '0;
    tiro_livre  = 3'b111;
    do_reset();
    last = 0; npulse = 0; prev = 1'b0; saw_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.fire_valid) saw_valid = 1'b1;
      if (prev) check_eq("ns_width", 32'(no_shooter), 32'd0);
      if (no_shooter && !prev) begin
        check_eq("ns_gap", 32'(k - last), 32'(CD + 1 + COLUNAS));
        last = k;
        npulse++;
      end
      prev = no_shooter;
    end
    check_eq("ns_count", 32'(npulse), 32'd4);
    check_eq("ns_no_valid", 32'(saw_valid), 32'd0);

    // No free slot: hold in SLOT, then slot 2 frees
    enemy_vivos = (32'h1 << 4) | (32'h1 << 12) | (32'h1 << 20) | (32'h1 << 28);
    tiro_livre  = 3'b000;
    do_reset();
    repeat (40) @(negedge clk);
    check_eq("slot_wait_state", 32'(state), 32'd4);
    check_eq("slot_wait_valid", 32'(bus.fire_valid), 32'd0);
    tiro_livre = 3'b100;
    e = {3'd2, 6'd4, 6'd3};
    exp_q.push_back(e);
    @(negedge clk);
    check_eq("slot_grant_valid", 32'(bus.fire_valid), 32'd1);
    check_eq("slot_grant", {bus.fire_slot, bus.fire_col, bus.fire_row},
             (exp_q.size() != 0) ? exp_q.pop_front() : 15'h7fff);

    // Request held without ack while enable toggles and the shooter dies
    enemy_vivos = '0;
    for (int k = 0; k < 50; k++) begin
      enable     = 1'($urandom_range(0, 1));
      tiro_livre = 3'($urandom_range(0, 7));
      @(negedge clk);
      check_eq("hold_no_ack", {bus.fire_valid, bus.fire_slot, bus.fire_col, bus.fire_row}, {1'b1, e});
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midfire_reset");
    reset  = 1'b0;
    enable = 1'b1;

    // 256 shots over random single-column grids: counter wraps
    do_reset();
    for (int k = 0; k < 256; k++) begin
      c    = $urandom_range(0, COLUNAS - 1);
      rows = 4'($urandom_range(1, 15));
      hr   = 0;
      enemy_vivos = '0;
      for (int r = 0; r < LINHAS; r++) begin
        if (rows[r]) begin
          enemy_vivos[r*COLUNAS + c] = 1'b1;
          hr = r;
        end
      end
      t = 3'($urandom_range(1, 7));
      tiro_livre = t;
      exp_q.push_back({low_slot(t), 6'(c), 6'(hr)});
      take_shot($urandom_range(0, 2));
    end
    check_eq("wrap", 32'(shots_fired), 32'd0);

    // Disabled for 100 cycles, then minimum-latency shot on a full grid
    enable      = 1'b0;
    enemy_vivos = '1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (state != 3'd0 || bus.fire_valid) bad = 1'b1;
    end
    check_eq("disabled_idle", 32'(bad), 32'd0);
    enable = 1'b1;
    n = 0;
    while (!bus.fire_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq("reenable_latency", 32'(n), 32'(CD + 4));
    check_eq("reenable_row", 32'(bus.fire_row), 32'd3);
    bus.fire_ack = 1'b1;
    @(negedge clk);
    bus.fire_ack = 1'b0;
    exp_shots++;
    check_eq("first_cycle_ack_valid", 32'(bus.fire_valid), 32'd0);
    check_eq("first_cycle_ack_shots", 32'(shots_fired), 32'(exp_shots));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
